// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring counter and its consumers.
// Ring widths up to RING_MAX are supported by the rotation helper.
package ring_pkg;

   localparam int RING_N   = 6;
   localparam int RING_MAX = 64;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   // Rotate the low n bits of vec left by one, bit n-1 wrapping to bit 0; upper bits are zero.
   function automatic logic [RING_MAX-1:0] rotl1(input logic [RING_MAX-1:0] vec, input int n);
      logic [RING_MAX-1:0] res;
      res    = '0;
      res[0] = vec[n-1];
      for (int i = 1; i < RING_MAX; i++) begin
         if (i < n) res[i] = vec[i-1];
      end
      return res;
   endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and binary encode of a ring sample.
// All-zero and multi-hot inputs report is_onehot = 0.
module ring_onehot_enc
   import ring_pkg::*;
#(
   parameter int N = RING_N
) (
   input  logic [N-1:0]         vec,
   output logic [$clog2(N)-1:0] idx,
   output logic                 is_onehot
);

   localparam int IW = $clog2(N);

   int hot_cnt;

   always_comb begin
      idx     = '0;
      hot_cnt = 0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx     = idx | IW'(i);
            hot_cnt = hot_cnt + 1;
         end
      end
      is_onehot = (hot_cnt == 1);
   end

endmodule

// File: rtl/ring_phase_decoder.sv
// Samples the one-hot ring every clk, checks each step is a left rotation of the last,
// and reports phase, wrap, lock state, revolution count and sequence faults (1-cycle latency).
module ring_phase_decoder
   import ring_pkg::*;
#(
   parameter int N        = RING_N,
   parameter int LOCK_CNT = 3,
   parameter int REV_W    = 16,
   parameter int ERR_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         ring_in,
   input  logic                 clear,
   output logic [$clog2(N)-1:0] phase,
   output logic                 phase_valid,
   output logic                 wrap,
   output logic                 locked,
   output logic [REV_W-1:0]     rev_count,
   output logic                 err_onehot,
   output logic                 err_seq,
   output logic                 err_sticky,
   output logic [ERR_W-1:0]     err_count
);

   localparam int PW = $clog2(N);
   localparam int GW = $clog2(LOCK_CNT + 1);

   state_t              state_q;
   logic [GW-1:0]       good_cnt_q;
   logic [N-1:0]        ref_q;
   logic [PW-1:0]       phase_q;
   logic                phase_valid_q;
   logic                wrap_q;
   logic                locked_q;
   logic [REV_W-1:0]    rev_count_q;
   logic                err_onehot_q;
   logic                err_seq_q;
   logic                err_sticky_q;
   logic [ERR_W-1:0]    err_count_q;

   logic [PW-1:0]       idx;
   logic                is_onehot;
   logic [RING_MAX-1:0] expected;
   logic                active;
   logic                good_step;
   logic                err_oh_d;
   logic                err_seq_d;
   logic                wrap_d;
   logic                lock_hit;
   logic [REV_W-1:0]    rev_count_d;
   logic [ERR_W-1:0]    err_count_d;
   logic                err_sticky_d;

   ring_onehot_enc #(.N(N)) u_enc (
      .vec       (ring_in),
      .idx       (idx),
      .is_onehot (is_onehot)
   );

   always_comb begin
      expected  = rotl1(RING_MAX'(ref_q), N);
      active    = (state_q != UNLOCKED);
      good_step = is_onehot && (expected == RING_MAX'(ring_in));
      err_oh_d  = active && !is_onehot;
      err_seq_d = active && is_onehot && !good_step;
      wrap_d    = active && good_step && ref_q[N-1];
      lock_hit  = (good_cnt_q == GW'(LOCK_CNT - 1));

      // clear wins over a same-cycle error or wrap
      rev_count_d = rev_count_q;
      if (clear)
         rev_count_d = '0;
      else if (wrap_d && state_q == LOCKED)
         rev_count_d = rev_count_q + REV_W'(1);

      err_count_d  = err_count_q;
      err_sticky_d = err_sticky_q;
      if (clear) begin
         err_count_d  = '0;
         err_sticky_d = 1'b0;
      end else if (err_oh_d || err_seq_d) begin
         err_sticky_d = 1'b1;
         if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= UNLOCKED;
         good_cnt_q    <= '0;
         ref_q         <= '0;
         phase_q       <= '0;
         phase_valid_q <= 1'b0;
         wrap_q        <= 1'b0;
         locked_q      <= 1'b0;
         rev_count_q   <= '0;
         err_onehot_q  <= 1'b0;
         err_seq_q     <= 1'b0;
         err_sticky_q  <= 1'b0;
         err_count_q   <= '0;
      end else begin
         wrap_q        <= wrap_d;
         err_onehot_q  <= err_oh_d;
         err_seq_q     <= err_seq_d;
         err_sticky_q  <= err_sticky_d;
         err_count_q   <= err_count_d;
         rev_count_q   <= rev_count_d;
         // Any one-hot sample leaves the FSM in ACQUIRE or LOCKED and becomes the new reference.
         phase_valid_q <= is_onehot;
         if (is_onehot) begin
            phase_q <= idx;
            ref_q   <= ring_in;
         end
         locked_q <= 1'b0;
         case (state_q)
            UNLOCKED: begin
               good_cnt_q <= '0;
               if (is_onehot) state_q <= ACQUIRE;
            end
            ACQUIRE: begin
               if (good_step) begin
                  if (lock_hit) begin
                     state_q    <= LOCKED;
                     good_cnt_q <= '0;
                     locked_q   <= 1'b1;
                  end else begin
                     good_cnt_q <= good_cnt_q + GW'(1);
                  end
               end else begin
                  good_cnt_q <= '0;
                  if (!is_onehot) state_q <= UNLOCKED;
               end
            end
            LOCKED: begin
               good_cnt_q <= '0;
               if (good_step)
                  locked_q <= 1'b1;
               else if (!is_onehot)
                  state_q <= UNLOCKED;
               else
                  state_q <= ACQUIRE;
            end
            default: begin
               state_q    <= UNLOCKED;
               good_cnt_q <= '0;
            end
         endcase
      end
   end

   assign phase       = phase_q;
   assign phase_valid = phase_valid_q;
   assign wrap        = wrap_q;
   assign locked      = locked_q;
   assign rev_count   = rev_count_q;
   assign err_onehot  = err_onehot_q;
   assign err_seq     = err_seq_q;
   assign err_sticky  = err_sticky_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Vector-table bench for ring_phase_decoder (N=6, LOCK_CNT=3); a second instance with
// ERR_W=2 shares the stimulus to exercise error-count saturation.
module tb_ring_phase_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] ring_in = '0;
   logic       clear = 1'b0;

   logic [2:0]  phase, phase2;
   logic        phase_valid, wrap, locked, err_onehot, err_seq, err_sticky;
   logic        phase_valid2, wrap2, locked2, err_onehot2, err_seq2, err_sticky2;
   logic [15:0] rev_count, rev_count2;
   logic [7:0]  err_count;
   logic [1:0]  err_count2;

   always #5 clk = ~clk;

   ring_phase_decoder #(.N(6), .LOCK_CNT(3), .REV_W(16), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .ring_in(ring_in), .clear(clear),
      .phase(phase), .phase_valid(phase_valid), .wrap(wrap), .locked(locked),
      .rev_count(rev_count), .err_onehot(err_onehot), .err_seq(err_seq),
      .err_sticky(err_sticky), .err_count(err_count)
   );

   ring_phase_decoder #(.N(6), .LOCK_CNT(3), .REV_W(16), .ERR_W(2)) dut_sat (
      .clk(clk), .rst(rst), .ring_in(ring_in), .clear(clear),
      .phase(phase2), .phase_valid(phase_valid2), .wrap(wrap2), .locked(locked2),
      .rev_count(rev_count2), .err_onehot(err_onehot2), .err_seq(err_seq2),
      .err_sticky(err_sticky2), .err_count(err_count2)
   );

   typedef struct packed {
      logic [5:0]  ring;
      logic        clr;
      logic [2:0]  ph;
      logic        pv;
      logic        w;
      logic        lk;
      logic [15:0] rev;
      logic        eo;
      logic        es;
      logic        st;
      logic [7:0]  ec;
   } vec_t;

   // {phase, phase_valid, wrap, locked, rev_count, err_onehot, err_seq, err_sticky, err_count, err_count(ERR_W=2)}
   typedef logic [34:0] obs_t;

   vec_t tbl[$];
   obs_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic add(input logic [5:0] ring, input logic clr, input logic [2:0] ph,
                      input logic pv, input logic w, input logic lk, input int rev,
                      input logic eo, input logic es, input logic st, input int ec);
      vec_t v;
      v.ring = ring; v.clr = clr; v.ph = ph; v.pv = pv; v.w = w; v.lk = lk;
      v.rev = 16'(rev); v.eo = eo; v.es = es; v.st = st; v.ec = 8'(ec);
      tbl.push_back(v);
   endtask

   function automatic obs_t expect_of(input vec_t v);
      logic [1:0] ec2;
      ec2 = (v.ec > 8'd3) ? 2'd3 : v.ec[1:0];
      return {v.ph, v.pv, v.w, v.lk, v.rev, v.eo, v.es, v.st, v.ec, ec2};
   endfunction

   function automatic obs_t observe();
      return {phase, phase_valid, wrap, locked, rev_count, err_onehot, err_seq,
              err_sticky, err_count, err_count2};
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   initial begin
      //   ring    clr ph pv w lk rev eo es st ec
      add(6'h01, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(6'h02, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(6'h04, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
      add(6'h08, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0);
      add(6'h10, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0);
      add(6'h20, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0);
      add(6'h01, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      add(6'h02, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
      add(6'h04, 0, 2, 1, 0, 1, 1, 0, 0, 0, 0);
      add(6'h00, 0, 2, 0, 0, 0, 1, 1, 0, 1, 1);
      add(6'h00, 0, 2, 0, 0, 0, 1, 0, 0, 1, 1);
      add(6'h04, 0, 2, 1, 0, 0, 1, 0, 0, 1, 1);
      add(6'h08, 0, 3, 1, 0, 0, 1, 0, 0, 1, 1);
      add(6'h10, 0, 4, 1, 0, 0, 1, 0, 0, 1, 1);
      add(6'h20, 0, 5, 1, 0, 1, 1, 0, 0, 1, 1);
      add(6'h01, 0, 0, 1, 1, 1, 2, 0, 0, 1, 1);
      add(6'h02, 0, 1, 1, 0, 1, 2, 0, 0, 1, 1);
      add(6'h04, 0, 2, 1, 0, 1, 2, 0, 0, 1, 1);
      add(6'h10, 0, 4, 1, 0, 0, 2, 0, 1, 1, 2);
      add(6'h20, 0, 5, 1, 0, 0, 2, 0, 0, 1, 2);
      add(6'h01, 0, 0, 1, 1, 0, 2, 0, 0, 1, 2);
      add(6'h02, 0, 1, 1, 0, 1, 2, 0, 0, 1, 2);
      add(6'h02, 0, 1, 1, 0, 0, 2, 0, 1, 1, 3);
      add(6'h08, 0, 3, 1, 0, 0, 2, 0, 1, 1, 4);
      add(6'h08, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0);
      add(6'h10, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
      add(6'h11, 0, 4, 0, 0, 0, 0, 1, 0, 1, 1);
      add(6'h03, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      add(6'h01, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++)
         add(6'h01, 0, 0, 1, 0, 0, 0, 0, 1, 1, k);
      add(6'h02, 0, 1, 1, 0, 0, 0, 0, 0, 1, 5);
      add(6'h04, 0, 2, 1, 0, 0, 0, 0, 0, 1, 5);
      add(6'h08, 0, 3, 1, 0, 1, 0, 0, 0, 1, 5);
      add(6'h10, 0, 4, 1, 0, 1, 0, 0, 0, 1, 5);
      add(6'h20, 0, 5, 1, 0, 1, 0, 0, 0, 1, 5);
      add(6'h01, 0, 0, 1, 1, 1, 1, 0, 0, 1, 5);
      add(6'h02, 0, 1, 1, 0, 1, 1, 0, 0, 1, 5);
      add(6'h04, 0, 2, 1, 0, 1, 1, 0, 0, 1, 5);
      add(6'h08, 0, 3, 1, 0, 1, 1, 0, 0, 1, 5);
      add(6'h10, 0, 4, 1, 0, 1, 1, 0, 0, 1, 5);
      add(6'h20, 0, 5, 1, 0, 1, 1, 0, 0, 1, 5);
      add(6'h01, 0, 0, 1, 1, 1, 2, 0, 0, 1, 5);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_state", observe(), '0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         ring_in = tbl[i].ring;
         clear   = tbl[i].clr;
         sb.push_back(expect_of(tbl[i]));
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: vector %0d had no expectation", i);
         end else begin
            check($sformatf("vec%0d", i), observe(), sb.pop_front());
         end
      end

      // Asynchronous reset mid-cycle while locked with rev_count = 2
      clear   = 1'b0;
      #2;
      rst     = 1'b1;
      #1;
      check("async_reset_before_edge", observe(), '0);
      ring_in = 6'h00;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_idle", observe(), '0);

      // Clean relock after reset: reference then 3 good steps
      ring_in = 6'h08;
      @(posedge clk); #1;
      ring_in = 6'h10;
      @(posedge clk); #1;
      ring_in = 6'h20;
      @(posedge clk); #1;
      check("relock_not_yet", {31'd0, locked, phase}, {31'd0, 1'b0, 3'd5});
      ring_in = 6'h01;
      @(posedge clk); #1;
      check("relock_after_3", {30'd0, locked, wrap, phase}, {30'd0, 1'b1, 1'b1, 3'd0});
      check("wrap_in_acquire_no_rev", {19'd0, rev_count}, 35'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
